// File: rtl/hms_display_pkg.sv
// Shared definitions for the HH.MM.SS display driver: field widths, segment
// patterns, digit positions, converter states and the double-dabble step.
package hms_display_pkg;

    localparam int HOUR_W   = 5;
    localparam int MINSEC_W = 6;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [2:0] DIG_SEC_ONES  = 3'd0;
    localparam logic [2:0] DIG_SEC_TENS  = 3'd1;
    localparam logic [2:0] DIG_MIN_ONES  = 3'd2;
    localparam logic [2:0] DIG_MIN_TENS  = 3'd3;
    localparam logic [2:0] DIG_HOUR_ONES = 3'd4;
    localparam logic [2:0] DIG_HOUR_TENS = 3'd5;

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        SHIFT   = 2'd1,
        COMMIT  = 2'd2
    } conv_state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Layout is {tens, ones, binary}: adjust both BCD nibbles, then shift left.
    function automatic logic [13:0] dabble_step(input logic [13:0] sr);
        logic [13:0] adj;
        adj = sr;
        if (adj[13:10] >= 4'd5) adj[13:10] = adj[13:10] + 4'd3;
        if (adj[9:6]   >= 4'd5) adj[9:6]   = adj[9:6]   + 4'd3;
        return {adj[12:0], 1'b0};
    endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Six-cycle serial double-dabble converter for one 6-bit field; the first
// shift happens in the start cycle and done pulses once the result is valid.
module bin2bcd_serial
    import hms_display_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [MINSEC_W-1:0] bin,
    output logic [3:0]          tens,
    output logic [3:0]          ones,
    output logic                done
);

    logic [13:0] sr;
    logic [2:0]  step_cnt;
    logic        busy;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sr       <= '0;
            step_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (start) begin
            sr       <= dabble_step({8'd0, bin});
            step_cnt <= 3'd1;
            busy     <= 1'b1;
            done     <= 1'b0;
        end else if (busy) begin
            sr       <= dabble_step(sr);
            step_cnt <= step_cnt + 3'd1;
            if (step_cnt == 3'd5) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

    assign tens = sr[13:10];
    assign ones = sr[9:6];

endmodule

// File: rtl/hms_display_driver.sv
// Snapshots H/M/S, converts to BCD with a shared serial engine, commits six
// digits at once and scans them. `LEADING_ZERO_BLANK_EN blanks a zero hour-tens.
module hms_display_driver
    import hms_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int REFRESH_W   = 17
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [HOUR_W-1:0]   hour_in,
    input  logic [MINSEC_W-1:0] min_in,
    input  logic [MINSEC_W-1:0] sec_in,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [7:0]          an
);

    conv_state_t         state;
    logic [HOUR_W-1:0]   snap_hour;
    logic [MINSEC_W-1:0] snap_min;
    logic [MINSEC_W-1:0] snap_sec;
    logic [4:0]          shift_cnt;
    logic [7:0]          hour_scr;
    logic [7:0]          min_scr;
    logic [23:0]         disp_reg;

    logic                eng_start;
    logic [MINSEC_W-1:0] eng_bin;
    logic [3:0]          eng_tens;
    logic [3:0]          eng_ones;
    logic                eng_done;

    logic [REFRESH_W-1:0] refresh_cnt;
    logic [2:0]           dig_idx;
    logic [3:0]           cur_digit;
    logic [6:0]           cur_seg;

    // Engine is relaunched every six SHIFT cycles: hour, then minute, then second.
    always_comb begin
        eng_start = (state == SHIFT) &&
                    (shift_cnt == 5'd0 || shift_cnt == 5'd6 || shift_cnt == 5'd12);
        if (shift_cnt < 5'd6)
            eng_bin = {{(MINSEC_W-HOUR_W){1'b0}}, snap_hour};
        else if (shift_cnt < 5'd12)
            eng_bin = snap_min;
        else
            eng_bin = snap_sec;
    end

    bin2bcd_serial u_bin2bcd (
        .clk    (clk),
        .resetn (resetn),
        .start  (eng_start),
        .bin    (eng_bin),
        .tens   (eng_tens),
        .ones   (eng_ones),
        .done   (eng_done)
    );

    // Seconds are still sitting in the engine during COMMIT, so they go straight in.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= CAPTURE;
            snap_hour <= '0;
            snap_min  <= '0;
            snap_sec  <= '0;
            shift_cnt <= '0;
            hour_scr  <= '0;
            min_scr   <= '0;
            disp_reg  <= '0;
        end else begin
            case (state)
                CAPTURE: begin
                    snap_hour <= hour_in;
                    snap_min  <= min_in;
                    snap_sec  <= sec_in;
                    shift_cnt <= '0;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    if (eng_done && shift_cnt == 5'd6)
                        hour_scr <= {eng_tens, eng_ones};
                    if (eng_done && shift_cnt == 5'd12)
                        min_scr <= {eng_tens, eng_ones};
                    if (shift_cnt == 5'd17)
                        state <= COMMIT;
                    else
                        shift_cnt <= shift_cnt + 5'd1;
                end
                COMMIT: begin
                    disp_reg <= {hour_scr, min_scr, eng_tens, eng_ones};
                    state    <= CAPTURE;
                end
                default: state <= CAPTURE;
            endcase
        end
    end

    always_comb begin
        case (dig_idx)
            DIG_SEC_ONES:  cur_digit = disp_reg[3:0];
            DIG_SEC_TENS:  cur_digit = disp_reg[7:4];
            DIG_MIN_ONES:  cur_digit = disp_reg[11:8];
            DIG_MIN_TENS:  cur_digit = disp_reg[15:12];
            DIG_HOUR_ONES: cur_digit = disp_reg[19:16];
            DIG_HOUR_TENS: cur_digit = disp_reg[23:20];
            default:       cur_digit = 4'hF;
        endcase
        cur_seg = seg_decode(cur_digit);
`ifdef LEADING_ZERO_BLANK_EN
        if (dig_idx == DIG_HOUR_TENS && cur_digit == 4'd0)
            cur_seg = SEG_BLANK;
`endif
    end

    // an and seg load together from the same index, so there is no ghosting.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            refresh_cnt <= '0;
            dig_idx     <= '0;
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
            an          <= 8'hFF;
        end else begin
            an  <= ~(8'd1 << dig_idx);
            seg <= cur_seg;
            dp  <= !(dig_idx == DIG_MIN_ONES || dig_idx == DIG_HOUR_ONES);
            if (refresh_cnt == REFRESH_W'(REFRESH_DIV - 1)) begin
                refresh_cnt <= '0;
                dig_idx     <= (dig_idx == DIG_HOUR_TENS) ? 3'd0 : dig_idx + 3'd1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hms_display_driver.sv
// Directed bench for hms_display_driver with a short refresh divider.
module tb_hms_display_driver;
    import hms_display_pkg::*;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [4:0] hour_in = '0;
    logic [5:0] min_in = '0;
    logic [5:0] sec_in = '0;
    logic [6:0] seg;
    logic       dp;
    logic [7:0] an;

    int compared = 0;
    int mismatched = 0;

    hms_display_driver #(.REFRESH_DIV(4), .REFRESH_W(3)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .hour_in (hour_in),
        .min_in  (min_in),
        .sec_in  (sec_in),
        .seg     (seg),
        .dp      (dp),
        .an      (an)
    );

    always #5 clk = ~clk;

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_an(input logic [7:0] target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (an === target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        wait_cycles(3);
        compared++;
        if (seg !== 7'h7F) begin mismatched++; $display("FAIL reset_seg: got %h expected 7f", seg); end
        compared++;
        if (dp !== 1'b1) begin mismatched++; $display("FAIL reset_dp: got %b expected 1", dp); end
        compared++;
        if (an !== 8'hFF) begin mismatched++; $display("FAIL reset_an: got %h expected ff", an); end
        resetn = 1'b1;
        @(negedge clk);
        compared++;
        if (an !== 8'hFE || seg !== 7'h40 || dp !== 1'b1) begin
            mismatched++;
            $display("FAIL first_clock: got an=%h seg=%h dp=%b expected fe/40/1", an, seg, dp);
        end
    endtask

    task automatic test_scan;
        int idx;
        logic [7:0] exp_an;
        logic exp_dp;
        for (int n = 2; n <= 24; n++) begin
            @(negedge clk);
            idx = (n - 1) / 4;
            exp_an = ~(8'd1 << idx);
            exp_dp = (idx == 2 || idx == 4) ? 1'b0 : 1'b1;
            compared++;
            if (an !== exp_an) begin mismatched++; $display("FAIL scan_an n=%0d: got %h expected %h", n, an, exp_an); end
            compared++;
            if (seg !== 7'h40) begin mismatched++; $display("FAIL scan_seg n=%0d: got %h expected 40", n, seg); end
            compared++;
            if (dp !== exp_dp) begin mismatched++; $display("FAIL scan_dp n=%0d: got %b expected %b", n, dp, exp_dp); end
        end
    endtask

    task automatic test_convert;
        logic [7:0] an_list [0:5];
        logic [6:0] seg_list [0:5];
        bit ok;
        an_list  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF};
        seg_list = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
        hour_in = 5'd12; min_in = 6'd34; sec_in = 6'd56;
        wait_cycles(45);
        compared++;
        if (dut.disp_reg !== 24'h123456) begin
            mismatched++;
            $display("FAIL convert_reg: got %h expected 123456", dut.disp_reg);
        end
        for (int i = 0; i < 6; i++) begin
            wait_an(an_list[i], ok);
            compared++;
            if (!ok || seg !== seg_list[i]) begin
                mismatched++;
                $display("FAIL convert_seg an=%h: got %h (found=%0b) expected %h", an_list[i], seg, ok, seg_list[i]);
            end
        end
    endtask

    task automatic test_coherent;
        bit found;
        int first_new;
        hour_in = 5'd5; min_in = 6'd59; sec_in = 6'd59;
        wait_cycles(45);
        compared++;
        if (dut.disp_reg !== 24'h055959) begin
            mismatched++;
            $display("FAIL coherent_old: got %h expected 055959", dut.disp_reg);
        end
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (dut.state == CAPTURE) begin
                found = 1'b1;
                break;
            end
        end
        compared++;
        if (!found) begin mismatched++; $display("FAIL coherent_capture: got timeout expected CAPTURE state"); end
        @(negedge clk);
        hour_in = 5'd6; min_in = 6'd0; sec_in = 6'd0;
        first_new = -1;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            compared++;
            if (first_new < 0 && dut.disp_reg === 24'h060000) first_new = k;
            if (first_new < 0 ? dut.disp_reg !== 24'h055959 : dut.disp_reg !== 24'h060000) begin
                mismatched++;
                $display("FAIL coherent_mix k=%0d: got %h expected %s", k, dut.disp_reg,
                         first_new < 0 ? "055959" : "060000");
            end
        end
        compared++;
        if (first_new != 39) begin
            mismatched++;
            $display("FAIL coherent_latency: got %0d expected 39", first_new);
        end
    endtask

    task automatic test_out_of_range;
        logic [7:0] an_list [0:3];
        logic [6:0] seg_list [0:3];
        bit ok;
        an_list  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};
        seg_list = '{7'h40, 7'h02, 7'h30, 7'h02};
        hour_in = 5'd0; min_in = 6'd63; sec_in = 6'd60;
        wait_cycles(45);
        compared++;
        if (dut.disp_reg !== 24'h006360) begin
            mismatched++;
            $display("FAIL range_reg: got %h expected 006360", dut.disp_reg);
        end
        for (int i = 0; i < 4; i++) begin
            wait_an(an_list[i], ok);
            compared++;
            if (!ok || $isunknown(seg) || seg !== seg_list[i]) begin
                mismatched++;
                $display("FAIL range_seg an=%h: got %h (found=%0b) expected %h", an_list[i], seg, ok, seg_list[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        bit found;
        hour_in = 5'd12; min_in = 6'd34; sec_in = 6'd56;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (dut.state == SHIFT) begin
                found = 1'b1;
                break;
            end
        end
        compared++;
        if (!found) begin mismatched++; $display("FAIL mid_shift: got timeout expected SHIFT state"); end
        wait_cycles(3);
        resetn = 1'b0;
        #1;
        compared++;
        if (seg !== 7'h7F || dp !== 1'b1 || an !== 8'hFF) begin
            mismatched++;
            $display("FAIL mid_reset_out: got seg=%h dp=%b an=%h expected 7f/1/ff", seg, dp, an);
        end
        compared++;
        if (dut.disp_reg !== 24'h000000) begin
            mismatched++;
            $display("FAIL mid_reset_reg: got %h expected 000000", dut.disp_reg);
        end
        @(negedge clk);
        resetn = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) begin
                compared++;
                if (an !== 8'hFE || seg !== 7'h40 || dp !== 1'b1) begin
                    mismatched++;
                    $display("FAIL mid_first: got an=%h seg=%h dp=%b expected fe/40/1", an, seg, dp);
                end
            end
            if (n == 19) begin
                compared++;
                if (dut.disp_reg !== 24'h000000) begin
                    mismatched++;
                    $display("FAIL mid_before_commit: got %h expected 000000", dut.disp_reg);
                end
            end
            if (n == 20) begin
                compared++;
                if (dut.disp_reg !== 24'h123456) begin
                    mismatched++;
                    $display("FAIL mid_first_commit: got %h expected 123456", dut.disp_reg);
                end
            end
        end
    endtask

    task automatic test_leading_zero;
        bit ok;
        logic [6:0] exp_seg;
`ifdef LEADING_ZERO_BLANK_EN
        exp_seg = 7'h7F;
`else
        exp_seg = 7'h40;
`endif
        hour_in = 5'd7; min_in = 6'd0; sec_in = 6'd0;
        wait_cycles(45);
        wait_an(8'hDF, ok);
        compared++;
        if (!ok || seg !== exp_seg) begin
            mismatched++;
            $display("FAIL lz_hour7: got %h (found=%0b) expected %h", seg, ok, exp_seg);
        end
        wait_an(8'hEF, ok);
        compared++;
        if (!ok || seg !== 7'h78) begin
            mismatched++;
            $display("FAIL lz_hour7_ones: got %h (found=%0b) expected 78", seg, ok);
        end
        hour_in = 5'd10;
        wait_cycles(45);
        wait_an(8'hDF, ok);
        compared++;
        if (!ok || seg !== 7'h79) begin
            mismatched++;
            $display("FAIL lz_hour10: got %h (found=%0b) expected 79", seg, ok);
        end
    endtask

    initial begin
        test_reset;
        test_scan;
        test_convert;
        test_coherent;
        test_out_of_range;
        test_reset_mid;
        test_leading_zero;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
